// File: rtl/onset_det_pkg.sv
// Shared definitions for the analysis blocks: sample width, onset FSM
// encoding and the saturating rectifier.
package onset_det_pkg;

  localparam int BITS = 16;

  typedef logic [BITS-1:0] level_t;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // |x| for a two's complement sample; the most-negative code saturates to max positive.
  function automatic level_t sat_abs(input level_t x);
    if (x == {1'b1, {(BITS-1){1'b0}}})
      return {1'b0, {(BITS-1){1'b1}}};
    else if (x[BITS-1])
      return -x;
    else
      return x;
  endfunction

endpackage

// File: rtl/onset_det_env_follow.sv
// Rectifier plus asymmetric attack/release envelope follower.
// o_level_next is the value the level register takes on the next ena cycle.
module env_follow
  import onset_det_pkg::*;
#(
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ena,
  input  logic [BITS-1:0] i_sample_in,
  output logic [BITS-1:0] o_level_next,
  output logic [BITS-1:0] o_level
);

  localparam logic [BITS:0] ONE_X = {{BITS{1'b0}}, 1'b1};

  logic [BITS-1:0] r_level;
  logic [BITS:0]   w_mag_x;
  logic [BITS:0]   w_lvl_x;
  logic [BITS:0]   w_diff;
  logic [BITS:0]   w_step;
  logic [BITS:0]   w_next_x;

  assign w_mag_x = {1'b0, sat_abs(i_sample_in)};
  assign w_lvl_x = {1'b0, r_level};

  // Minimum step of 1 so the follower lands exactly on the magnitude.
  always_comb begin
    w_diff   = '0;
    w_step   = '0;
    w_next_x = w_lvl_x;
    if (w_mag_x > w_lvl_x) begin
      w_diff   = w_mag_x - w_lvl_x;
      w_step   = w_diff >> ATTACK_SHIFT;
      if (w_step == '0) w_step = ONE_X;
      w_next_x = w_lvl_x + w_step;
    end else if (w_mag_x < w_lvl_x) begin
      w_diff   = w_lvl_x - w_mag_x;
      w_step   = w_diff >> RELEASE_SHIFT;
      if (w_step == '0) w_step = ONE_X;
      w_next_x = w_lvl_x - w_step;
    end
  end

  assign o_level_next = w_next_x[BITS] ? {BITS{1'b1}} : w_next_x[BITS-1:0];
  assign o_level      = r_level;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_level <= '0;
    else if (i_ena)
      r_level <= o_level_next;
  end

endmodule

// File: rtl/onset_det.sv
// Hysteresis onset detector: fires a one-clock trigger when the envelope
// crosses the on threshold and holds gate for at least HOLDOFF+1 ena cycles.
//
// state  | meaning
// IDLE   | waiting for levelNext >= on threshold
// ACTIVE | gate high; holdoff running, then waiting for levelNext < off threshold
module onset_det
  import onset_det_pkg::*;
#(
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8,
  parameter int HOLDOFF       = 1000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ena,
  input  logic [BITS-1:0] i_sample_in,
  input  logic [BITS-1:0] i_thresh_on,
  input  logic [BITS-1:0] i_thresh_off,
  output logic            o_trigger,
  output logic            o_gate,
  output logic [BITS-1:0] o_level
);

  localparam int CW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  logic [0:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_trig;
  logic [BITS-1:0] w_level_next;
  logic [BITS-1:0] w_thresh_off_eff;

  env_follow #(
    .ATTACK_SHIFT  (ATTACK_SHIFT),
    .RELEASE_SHIFT (RELEASE_SHIFT)
  ) u_follow (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ena        (i_ena),
    .i_sample_in  (i_sample_in),
    .o_level_next (w_level_next),
    .o_level      (o_level)
  );

  assign w_thresh_off_eff = (i_thresh_off < i_thresh_on) ? i_thresh_off : i_thresh_on;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_trig  <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      if (i_ena) begin
        case (r_state)
          ST_IDLE: begin
            if (w_level_next >= i_thresh_on) begin
              r_state <= ST_ACTIVE;
              r_cnt   <= CW'(HOLDOFF);
              r_trig  <= 1'b1;
            end
          end
          default: begin
            // No retrigger while active; only the release path is considered.
            if (r_cnt != '0)
              r_cnt <= r_cnt - CW'(1);
            else if (w_level_next < w_thresh_off_eff)
              r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_trigger = r_trig;
  assign o_gate    = (r_state == ST_ACTIVE);

endmodule

// File: doc/onset_det.md
# onset_det

Envelope follower and hysteresis onset detector: turns a signed audio sample stream into a one-cycle `trigger` pulse plus a sustained `gate`. It is the analysis end of the trigger path: `bitseq` and `env` consume triggers to make sound, and `onset_det` recovers triggers from sound. Its `trigger` output connects directly to an `env` trigger input or to any other module that takes a trigger.

## Interface
- `ATTACK_SHIFT`, default 2: follower rise coefficient, step = diff >> ATTACK_SHIFT.
- `RELEASE_SHIFT`, default 8: follower fall coefficient, step = diff >> RELEASE_SHIFT.
- `HOLDOFF`, default 1000: minimum gate length, counted in ena cycles; 0 allowed.
- `clk`  in  1  system clock; the block has one clock.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  sample strobe; one input sample is processed per high cycle.
- `sampleIn`  in  `BITS` signed  audio sample.
- `threshOn`  in  `BITS` unsigned  level at which an onset fires.
- `threshOff`  in  `BITS` unsigned  release level; effective off threshold = min(threshOff, threshOn).
- `trigger`  out  1  one-clk pulse per detected onset.
- `gate`  out  1  high while an onset is active.
- `level`  out  `BITS` unsigned  current follower value, in range 0..2^(BITS-1)-1.

## Operation
- Rectify: mag = |sampleIn|. The most-negative input saturates to 2^(BITS-1)-1.
- Follower update, on ena cycles only; arithmetic in BITS+1 bits, so no overflow is possible:
  - if mag > level: level += max(1, (mag-level) >> ATTACK_SHIFT);
  - if mag < level: level -= max(1, (level-mag) >> RELEASE_SHIFT);
  - if equal: level is unchanged.
  - The minimum step of 1 guarantees exact convergence to mag.
- Comparisons use the combinational next value `levelNext`, not the registered `level`.
- FSM has two states, IDLE and ACTIVE. It advances only on ena cycles.
  - IDLE, ena, levelNext >= threshOn: go to ACTIVE, load holdoff counter with HOLDOFF, and pulse `trigger`.
  - ACTIVE, ena, counter != 0: decrement the counter.
  - ACTIVE, ena, counter == 0, levelNext < effective off threshold: go to IDLE.
  - ACTIVE: there is no retrigger; levelNext >= threshOn is ignored.
- `gate` = (state == ACTIVE), registered.
- ena low: level, state and counter all hold; `trigger` is 0.
- Thresholds are sampled live and may change at any time. A change takes effect on the next ena cycle.

## Timing
- Latency: an ena cycle N that satisfies the fire condition produces `trigger`=1 and `gate`=1 in cycle N+1.
- `trigger` is high for exactly one clk. It is never high on two consecutive cycles, even when ena is held high continuously.
- `level` register reflects cycle N's sample from cycle N+1.
- Release: gate falls in the clk cycle after the releasing ena cycle.
- Minimum gate length = HOLDOFF+1 ena cycles.
- Reset takes priority over ena. In the cycle after rst: level=0, state IDLE, counter=0, trigger=0, gate=0. This includes reset asserted mid-ACTIVE or in the same cycle as a fire condition.
- threshOn = 0: the block fires on the first ena cycle after reset, then holds gate high permanently, because nothing is below an off threshold of 0.

## Structure
- `BITS` comes from the shared globals header.
- The state encoding (IDLE/ACTIVE) and the saturating-abs helper belong in a shared package. Other analysis blocks will reuse them.
- One natural sub-module: `env_follow`. It takes clk, rst, ena and sampleIn and produces levelNext and level, implementing the rectifier and follower. `onset_det` wraps it with the FSM and holdoff counter.
- Holdoff counter width = $clog2(HOLDOFF+1), with a minimum of 1.

## Test plan
All scenarios use BITS=16.
- Reset: hold rst for 3 cycles with ena=1 and sampleIn=16'h7000 -> level, trigger and gate stay 0 throughout. Level first becomes nonzero on the cycle after rst drops.
- Step onset: ATTACK_SHIFT=0, threshOn=16'h2000, sampleIn=16'h4000, ena=1 from cycle 0 -> level=16'h4000 and trigger=1 in cycle 1; trigger=0 in cycle 2; gate stays high.
- Saturation: sampleIn=16'h8000 with ATTACK_SHIFT=0 -> level=16'h7FFF, never 16'h8000.
- Hysteresis and holdoff: HOLDOFF=4, threshOn=16'h2000, threshOff=16'h1000; fire, then drive sampleIn=0 -> gate stays high until at least 5 ena cycles have elapsed and level < 16'h1000. There is no second trigger while level stays between 16'h1000 and 16'h2000.
- Sparse ena: ena high 1 in 4 cycles while sampleIn toggles on every cycle -> level changes only after ena cycles, and trigger never fires on an ena-low cycle.
- Reset mid-ACTIVE, then chain to `env`: assert rst while gate=1 -> gate=0 next cycle. After release, a fresh onset produces one trigger, and a connected `env` instance starts exactly one envelope.
